lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that drives the data memory port on behalf of the CPU pipeline. It accepts one byte-addressed load or store request at a time and performs sub-word access on the 64-bit word memory:

- Loads are extracted and extended from the word read.
- Sub-word stores use read-modify-write.
- Full-word stores are written directly.

It sits between the execute stage and the data memory, and is the only master on the memory's combinational-read / clocked-write port.

## Interface

Parameters:

- Bits, 64, data word width. Only 64 is supported; it gives 8 byte lanes.
- MemSize, 16, number of words in the attached memory. Used for the range check.

Ports. Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word(32), 11 dword(64)
- req_signed  in  1  loads: sign-extend (1) or zero-extend (0)
- req_addr  in  Bits  byte address
- req_wdata  in  Bits  store data, right-aligned in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  Bits  extended load data (0 for stores and errors)
- resp_err  out  1  request rejected (misaligned or out of range), valid with resp_valid
- mem_access_addr  out  Bits  word index = req_addr >> 3
- mem_write_data  out  Bits  full merged word
- mem_write_en  out  1  write strobe, sampled by the memory at posedge
- mem_read  out  1  read enable
- mem_read_data  in  Bits  combinational read data, valid in the same cycle as mem_read

## Operation

- **States:** IDLE, READ, WRITE, RESP.
- **Acceptance:**
  - req_ready = 1 only in IDLE.
  - A request is accepted on a clock edge where req_valid && req_ready. All request fields are latched at that edge.
- **Address:**
  - Offset = addr[2:0]; index = addr >> 3. Byte lane k is bits [8k+7:8k] (little-endian).
  - Out of range: index ≥ MemSize sets resp_err.
  - Misaligned: offset not a multiple of the access size (1/2/4/8) sets resp_err, subject to Configuration.
- **Transitions from IDLE on accept:**
  - Error: go to RESP. No memory access occurs.
  - Load: go to READ, then RESP.
  - dword store: go to WRITE, then RESP.
  - Sub-word store: go to READ, then WRITE, then RESP.
  - RESP always returns to IDLE.
- **READ:**
  - mem_read = 1.
  - The memory word is captured into an internal register at the end of the cycle.
- **Load result:**
  - Select the size-wide field at the offset.
  - Extend to 64 bits according to req_signed; dword is passed through.
- **WRITE:**
  - mem_write_en = 1 for exactly one cycle.
  - mem_write_data = captured word with the addressed lanes replaced by the low bytes of req_wdata.
  - For dword, mem_write_data = req_wdata.
- **RESP:**
  - resp_valid = 1 for one cycle. There is no backpressure.
  - resp_rdata and resp_err are held until the next RESP.
- **Idle outputs:** outside READ, mem_read = 0. Outside WRITE, mem_write_en = 0 and mem_write_data = 0.
- **mem_access_addr:** always the latched word index, so it is stable across READ→WRITE.
- **Reset values:** state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_access_addr 0, mem_write_data 0, mem_write_en 0, mem_read 0.
- **Reset mid-operation:**
  - The pending request is dropped; no response is issued.
  - If the reset edge ends a READ, the following WRITE never occurs.
  - req_ready = 1 in the first cycle after reset.

## Timing

Cycle 0 is the accept edge; the cycles below are counted from it.

- **Load:** READ in cycle 1; resp_valid in cycle 2; req_ready back high in cycle 3.
- **dword store:** WRITE in cycle 1 (memory updated at its end edge); resp_valid in cycle 2.
- **Sub-word store:** READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
- **Error:** resp_valid in cycle 1; mem_read and mem_write_en stay 0 throughout.
- **Throughput:** at most one outstanding request. Back-to-back requests are separated by at least one IDLE cycle.

## Configuration

- **Macro:** `LSU_ALIGN_CHECK_EN`.
- **Defined:**
  - Misaligned requests complete with resp_err = 1.
  - No memory access occurs for them.
- **Undefined:**
  - No misalignment error is raised.
  - The offset is truncated down to the size boundary (addr[2:0] & ~(size_bytes-1)) and the access proceeds.
  - The out-of-range check stays active in both builds.

## Test plan

- **Byte loads, sign and zero extension.** Word 2 = 0x1122334455667788.
  - Signed byte load, addr 0x10 → resp_rdata = 0xFFFFFFFFFFFFFF88 in cycle 2.
  - Unsigned byte load, same address → 0x0000000000000088.
- **Half store (read-modify-write).** Half store addr 0x12, wdata 0xABCD, word 2 as above.
  - mem_read in cycle 1, then mem_write_en in cycle 2 with mem_write_data = 0x11223344ABCD7788.
  - resp_valid in cycle 3.
- **dword store.** dword store addr 0x18, wdata 0xDEADBEEFCAFEF00D.
  - Single write cycle to index 3, no mem_read.
  - Subsequent dword load returns the same value.
- **Misaligned access.** Word load addr 0x12.
  - With `LSU_ALIGN_CHECK_EN`: resp_err = 1 in cycle 1, no memory strobes.
  - Without it: reads offset 0 of word 2 → 0x0000000055667788 (unsigned).
- **Out of range.** Load addr 0x80 (index 16 ≥ MemSize) → resp_err = 1, resp_rdata = 0, no memory strobes.
- **Reset mid-operation.** Assert rst_n = 0 during cycle 1 (READ) of a byte store.
  - No mem_write_en pulse and no resp_valid.
  - Memory unchanged; req_ready = 1 in the cycle after release.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory port bundle for lsu_mem_master.
// The master modport is the LSU's view; slave is the CPU/memory side.
interface lsu_mem_master_if #(
  parameter int Bits = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [Bits-1:0] req_addr;
  logic [Bits-1:0] req_wdata;
  logic            resp_valid;
  logic [Bits-1:0] resp_rdata;
  logic            resp_err;
  logic [Bits-1:0] mem_access_addr;
  logic [Bits-1:0] mem_write_data;
  logic            mem_write_en;
  logic            mem_read;
  logic [Bits-1:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: sub-word loads with extension, read-modify-write sub-word stores.
// Define LSU_ALIGN_CHECK_EN to reject misaligned requests; otherwise the offset is truncated.
module lsu_mem_master #(
  parameter int Bits    = 64,
  parameter int MemSize = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state;
  logic            lat_write;
  logic [1:0]      lat_size;
  logic            lat_signed;
  logic [2:0]      lat_off;
  logic [Bits-1:0] lat_wdata;

  logic [Bits-1:0] req_idx;
  logic [2:0]      align_mask;
  logic [2:0]      req_off;
  logic            req_err;

  function automatic logic [Bits-1:0] load_extend(input logic [Bits-1:0] word,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            sgn);
    logic [Bits-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = {{(Bits-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{(Bits-16){sgn & sh[15]}}, sh[15:0]};
      2'b10:   load_extend = {{(Bits-32){sgn & sh[31]}}, sh[31:0]};
      default: load_extend = sh;
    endcase
  endfunction

  function automatic logic [Bits-1:0] store_merge(input logic [Bits-1:0] word,
                                                  input logic [Bits-1:0] wdata,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size);
    logic [Bits-1:0] lane_mask;
    case (size)
      2'b00:   lane_mask = {{(Bits-8){1'b0}}, 8'hFF};
      2'b01:   lane_mask = {{(Bits-16){1'b0}}, 16'hFFFF};
      2'b10:   lane_mask = {{(Bits-32){1'b0}}, 32'hFFFF_FFFF};
      default: lane_mask = '1;
    endcase
    lane_mask   = lane_mask << {off, 3'b000};
    store_merge = (word & ~lane_mask) | ((wdata << {off, 3'b000}) & lane_mask);
  endfunction

  // Request classification happens on the raw inputs at the accept edge.
  always_comb begin
    req_idx    = bus.req_addr >> 3;
    align_mask = 3'b111 << bus.req_size;
`ifdef LSU_ALIGN_CHECK_EN
    req_off = bus.req_addr[2:0];
    req_err = (req_idx >= Bits'(MemSize)) || (|(bus.req_addr[2:0] & ~align_mask));
`else
    req_off = bus.req_addr[2:0] & align_mask;
    req_err = (req_idx >= Bits'(MemSize));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.req_ready       <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_err        <= 1'b0;
      bus.mem_access_addr <= '0;
      bus.mem_write_data  <= '0;
      bus.mem_write_en    <= 1'b0;
      bus.mem_read        <= 1'b0;
    end else begin
      bus.resp_valid     <= 1'b0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_write_data <= '0;
      bus.mem_read       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready       <= 1'b0;
            lat_write           <= bus.req_write;
            lat_size            <= bus.req_size;
            lat_signed          <= bus.req_signed;
            lat_off             <= req_off;
            lat_wdata           <= bus.req_wdata;
            bus.mem_access_addr <= req_idx;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= '0;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_write && bus.req_size == 2'b11) begin
              state              <= WRITE;
              bus.mem_write_en   <= 1'b1;
              bus.mem_write_data <= bus.req_wdata;
            end else begin
              state        <= READ;
              bus.mem_read <= 1'b1;
            end
          end
        end
        // The read word is consumed directly at the end of READ: merged for stores, extended for loads.
        READ: begin
          if (lat_write) begin
            state              <= WRITE;
            bus.mem_write_en   <= 1'b1;
            bus.mem_write_data <= store_merge(bus.mem_read_data, lat_wdata, lat_off, lat_size);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_extend(bus.mem_read_data, lat_off, lat_size, lat_signed);
            bus.resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: byte-level reference model, per-cycle compare, literal pins.
module tb_lsu_mem_master;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int NCYC = 4096;

  logic clk;
  logic rst_n;
  int   cyc;
  bit   chk_en;
  bit   mem_load;
  int   n_chk;
  int   n_err;

  lsu_mem_master_if #(.Bits(64)) bus ();

  lsu_mem_master #(.Bits(64), .MemSize(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Attached memory: combinational read, clocked write.
  logic [63:0] mem [0:15];
  logic [63:0] exp_mem [0:15];

  function automatic logic [63:0] init_word(input int i);
    if (i == 2) return 64'h1122334455667788;
    return {32'hA5A50000 | i, 32'h0F0F0000 | i};
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (bus.mem_write_en && bus.mem_access_addr < 64'd16) begin
      mem[bus.mem_access_addr[3:0]] <= bus.mem_write_data;
    end
  end

  assign bus.mem_read_data = (bus.mem_access_addr < 64'd16) ? mem[bus.mem_access_addr[3:0]] : 64'h0;

  // Expected per-cycle outputs, indexed by the cycle counter value seen at the falling edge.
  logic        exp_ready [0:NCYC-1];
  logic        exp_rd    [0:NCYC-1];
  logic        exp_we    [0:NCYC-1];
  logic        exp_rv    [0:NCYC-1];
  logic        exp_err   [0:NCYC-1];
  logic [63:0] exp_wdata [0:NCYC-1];
  logic [63:0] exp_rdata [0:NCYC-1];
  logic [63:0] exp_addr  [0:NCYC-1];

  logic [63:0] last_rdata;
  logic        last_err;
  logic [63:0] last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc >= NCYC) begin
        chk("cycle_budget", 64'(cyc), 64'(NCYC - 1));
      end else begin
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready[cyc]));
        chk("mem_read", 64'(bus.mem_read), 64'(exp_rd[cyc]));
        chk("mem_write_en", 64'(bus.mem_write_en), 64'(exp_we[cyc]));
        chk("mem_write_data", bus.mem_write_data, exp_wdata[cyc]);
        chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv[cyc]));
        if (exp_rd[cyc] || exp_we[cyc]) chk("mem_access_addr", bus.mem_access_addr, exp_addr[cyc]);
        if (exp_rv[cyc]) begin
          chk("resp_rdata", bus.resp_rdata, exp_rdata[cyc]);
          chk("resp_err", 64'(bus.resp_err), 64'(exp_err[cyc]));
        end
      end
      if (bus.resp_valid) begin
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
      end
      if (bus.mem_write_en) last_wdata = bus.mem_write_data;
    end
  end

  task automatic drive_req(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Model: derive the whole transaction outcome and its cycle schedule from the request.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [63:0] a, input logic [63:0] wd);
    int          nb, off, n, c0;
    logic [63:0] idx, v, nw;
    bit          err;
    drive_req(w, sz, sg, a, wd);
    c0  = cyc;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    idx = a >> 3;
    err = (idx >= 64'd16) || (ALIGN && (off % nb != 0));
    if (!ALIGN) off = off - (off % nb);
    if (err) begin
      n = 1;
      exp_rdata[c0] = 64'h0;
      exp_err[c0]   = 1'b1;
    end else if (!w) begin
      n = 2;
      v = 64'h0;
      for (int b = 0; b < nb; b++) v[8*b +: 8] = exp_mem[idx[3:0]][8*(off+b) +: 8];
      if (sg && nb < 8 && v[8*nb-1])
        for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
      exp_rd[c0]      = 1'b1;
      exp_addr[c0]    = idx;
      exp_rdata[c0+1] = v;
      exp_err[c0+1]   = 1'b0;
    end else begin
      nw = exp_mem[idx[3:0]];
      for (int b = 0; b < nb; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
      n = (nb == 8) ? 2 : 3;
      if (nb != 8) begin
        exp_rd[c0]   = 1'b1;
        exp_addr[c0] = idx;
      end
      exp_we[c0+n-2]    = 1'b1;
      exp_wdata[c0+n-2] = nw;
      exp_addr[c0+n-2]  = idx;
      exp_rdata[c0+n-1] = 64'h0;
      exp_err[c0+n-1]   = 1'b0;
      exp_mem[idx[3:0]] = nw;
    end
    exp_rv[c0+n-1] = 1'b1;
    for (int k = 0; k < n; k++) exp_ready[c0+k] = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_ready[i] = 1'b1; exp_rd[i] = 1'b0; exp_we[i] = 1'b0; exp_rv[i] = 1'b0;
      exp_err[i] = 1'b0; exp_wdata[i] = 64'h0; exp_rdata[i] = 64'h0; exp_addr[i] = 64'h0;
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    n_chk = 0; n_err = 0; cyc = 0; chk_en = 1'b0; mem_load = 1'b1;
    last_rdata = 64'h0; last_err = 1'b0; last_wdata = 64'h0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    mem_load = 1'b0;
    chk("rst_resp_rdata", bus.resp_rdata, 64'h0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'h0);
    chk("rst_mem_access_addr", bus.mem_access_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 2'b00, 1'b1, 64'h10, 64'h0);
    chk("lit_lb_signed", last_rdata, 64'hFFFFFFFFFFFFFF88);
    do_req(1'b0, 2'b00, 1'b0, 64'h10, 64'h0);
    chk("lit_lbu", last_rdata, 64'h0000000000000088);
    do_req(1'b0, 2'b10, 1'b0, 64'h12, 64'h0);
    chk("lit_lw_misaligned", last_rdata, ALIGN ? 64'h0 : 64'h0000000055667788);
    chk("lit_lw_misaligned_err", 64'(last_err), ALIGN ? 64'h1 : 64'h0);
    do_req(1'b0, 2'b01, 1'b1, 64'h14, 64'h0);
    chk("lit_lh_signed_pos", last_rdata, 64'h0000000000003344);
    do_req(1'b1, 2'b01, 1'b0, 64'h12, 64'hABCD);
    chk("lit_sh_merge", last_wdata, 64'h11223344ABCD7788);
    do_req(1'b0, 2'b01, 1'b0, 64'h12, 64'h0);
    chk("lit_lhu_after_sh", last_rdata, 64'h000000000000ABCD);
    do_req(1'b1, 2'b11, 1'b0, 64'h18, 64'hDEADBEEFCAFEF00D);
    chk("lit_sd_data", last_wdata, 64'hDEADBEEFCAFEF00D);
    do_req(1'b0, 2'b11, 1'b1, 64'h18, 64'h0);
    chk("lit_ld_after_sd", last_rdata, 64'hDEADBEEFCAFEF00D);
    do_req(1'b1, 2'b10, 1'b0, 64'h24, 64'h80000001);
    do_req(1'b0, 2'b10, 1'b1, 64'h24, 64'h0);
    chk("lit_lw_signed_neg", last_rdata, 64'hFFFFFFFF80000001);
    do_req(1'b0, 2'b00, 1'b0, 64'h80, 64'h0);
    chk("lit_oor_load_err", 64'(last_err), 64'h1);
    chk("lit_oor_load_rdata", last_rdata, 64'h0);
    do_req(1'b1, 2'b00, 1'b0, 64'h400, 64'h55);
    chk("lit_oor_store_err", 64'(last_err), 64'h1);

    // Reset lands on the edge that ends READ of a byte store: nothing must follow.
    drive_req(1'b1, 2'b00, 1'b0, 64'h08, 64'h77);
    exp_rd[cyc]    = 1'b1;
    exp_addr[cyc]  = 64'h1;
    exp_ready[cyc] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_mem_unchanged", mem[1], 64'hA5A500010F0F0001);

    do_req(1'b0, 2'b00, 1'b1, 64'h0F, 64'h0);
    chk("lit_lb_after_reset", last_rdata, 64'hFFFFFFFFFFFFFFA5);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("mem_final_%0d", i), mem[i], exp_mem[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
